// File: rtl/alu_exec_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_exec_seq_if : execute-stage bundle between datapath and ALU/divider  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface alu_exec_seq_if #(
   parameter int WIDTH = 32
);
   logic             op_valid;
   logic [1:0]       alu_op;
   logic [5:0]       funct;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [3:0]       alu_control;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             stall;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output op_valid, alu_op, funct, src_a, src_b,
      input  alu_control, result, zero, stall, div_by_zero, hi, lo
   );

   modport slave (
      input  op_valid, alu_op, funct, src_a, src_b,
      output alu_control, result, zero, stall, div_by_zero, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/alu_exec_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_exec_seq : ALU decode + single-cycle ops + iterative DIV/DIVU (HI/LO) |
// | Optional macro MULT_EN adds shift-add MULT/MULTU on the same sequencer.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module alu_exec_seq #(
   parameter int WIDTH = 32
) (
   input  wire logic     clk,
   input  wire logic     reset,
   alu_exec_seq_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] c_iters = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] c_last  = CNT_W'(1);

   localparam logic [3:0] c_and  = 4'b0000;
   localparam logic [3:0] c_or   = 4'b0001;
   localparam logic [3:0] c_add  = 4'b0010;
   localparam logic [3:0] c_sub  = 4'b0110;
   localparam logic [3:0] c_slt  = 4'b0111;
   localparam logic [3:0] c_mult = 4'b1000;
   localparam logic [3:0] c_multu= 4'b1001;
   localparam logic [3:0] c_div  = 4'b1010;
   localparam logic [3:0] c_divu = 4'b1011;
   localparam logic [3:0] c_mfhi = 4'b1100;
   localparam logic [3:0] c_mflo = 4'b1101;
   localparam logic [3:0] c_bad  = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dbz;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
`ifdef MULT_EN
   logic             r_is_mul;
   logic [WIDTH:0]   w_sum;
   logic [2*WIDTH-1:0] w_prod;
`endif

   logic [3:0]       w_code;
   logic [WIDTH-1:0] w_result;
   logic             w_is_div;
   logic             w_is_seq;
   logic             w_signed;
   logic             w_issue;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_step_hi;
   logic [WIDTH-1:0] w_step_lo;
   logic [WIDTH-1:0] w_fin_hi;
   logic [WIDTH-1:0] w_fin_lo;

   always_comb begin
      w_code = c_bad;
      case (bus.alu_op)
         2'b00:   w_code = c_add;
         2'b01:   w_code = c_sub;
         2'b11:   w_code = c_and;
         default: begin
            case (bus.funct)
               6'b100000: w_code = c_add;
               6'b100010: w_code = c_sub;
               6'b101010: w_code = c_slt;
               6'b100100: w_code = c_and;
               6'b100101: w_code = c_or;
               6'b011010: w_code = c_div;
               6'b011011: w_code = c_divu;
               6'b010000: w_code = c_mfhi;
               6'b010010: w_code = c_mflo;
`ifdef MULT_EN
               6'b011000: w_code = c_mult;
               6'b011001: w_code = c_multu;
`endif
               default:   w_code = c_bad;
            endcase
         end
      endcase
   end

   always_comb begin
      w_result = '0;
      case (w_code)
         c_add:   w_result = bus.src_a + bus.src_b;
         c_sub:   w_result = bus.src_a - bus.src_b;
         c_slt:   w_result = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
         c_and:   w_result = bus.src_a & bus.src_b;
         c_or:    w_result = bus.src_a | bus.src_b;
         c_mfhi:  w_result = r_hi;
         c_mflo:  w_result = r_lo;
         default: w_result = '0;
      endcase
   end

   assign w_is_div = (w_code == c_div) || (w_code == c_divu);
`ifdef MULT_EN
   assign w_is_seq = w_is_div || (w_code == c_mult) || (w_code == c_multu);
   assign w_signed = (w_code == c_div) || (w_code == c_mult);
`else
   assign w_is_seq = w_is_div;
   assign w_signed = (w_code == c_div);
`endif
   assign w_issue  = (r_state == S_IDLE) && bus.op_valid && w_is_seq;
   assign w_a_neg  = w_signed && bus.src_a[WIDTH-1];
   assign w_b_neg  = w_signed && bus.src_b[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -bus.src_a : bus.src_a;
   assign w_b_mag  = w_b_neg ? -bus.src_b : bus.src_b;

   // One restoring divide step (or shift-add multiply step) per BUSY cycle.
   always_comb begin
      w_shift   = {r_rem, r_quo[WIDTH-1]};
      w_ge      = (w_shift >= {1'b0, r_div});
      w_step_hi = w_ge ? WIDTH'(w_shift - {1'b0, r_div}) : w_shift[WIDTH-1:0];
      w_step_lo = {r_quo[WIDTH-2:0], w_ge};
      w_fin_hi  = r_neg_r ? -r_rem : r_rem;
      w_fin_lo  = r_neg_q ? -r_quo : r_quo;
`ifdef MULT_EN
      w_sum     = {1'b0, r_rem} + {1'b0, (r_quo[0] ? r_div : {WIDTH{1'b0}})};
      w_prod    = r_neg_q ? -{r_rem, r_quo} : {r_rem, r_quo};
      if (r_is_mul) begin
         w_step_hi = w_sum[WIDTH:1];
         w_step_lo = {w_sum[0], r_quo[WIDTH-1:1]};
         w_fin_hi  = w_prod[2*WIDTH-1:WIDTH];
         w_fin_lo  = w_prod[WIDTH-1:0];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_div   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dbz   <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
`ifdef MULT_EN
         r_is_mul <= 1'b0;
`endif
      end else begin
         r_dbz <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_cnt   <= c_iters;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
`ifdef MULT_EN
                  r_is_mul <= !w_is_div;
`endif
                  // Zero divisor skips iteration; DONE then publishes LO=~0, HI=dividend.
                  if (w_is_div && (bus.src_b == '0)) begin
                     r_rem   <= bus.src_a;
                     r_quo   <= '1;
                     r_neg_q <= 1'b0;
                     r_neg_r <= 1'b0;
                     r_dbz   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_rem   <= '0;
                     r_quo   <= w_a_mag;
                     r_div   <= w_b_mag;
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               r_rem <= w_step_hi;
               r_quo <= w_step_lo;
               r_cnt <= r_cnt - c_last;
               if (r_cnt == c_last) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_hi    <= w_fin_hi;
               r_lo    <= w_fin_lo;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.alu_control = w_code;
   assign bus.result      = w_result;
   assign bus.zero        = (w_result == '0);
   assign bus.stall       = w_issue || (r_state == S_BUSY);
   assign bus.div_by_zero = r_dbz;
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_exec_seq : randomized + directed bench with a behavioural model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_alu_exec_seq;
   localparam int W = 32;

   logic clk;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   chk_en  = 1'b0;

   alu_exec_seq_if #(.WIDTH(W)) bus ();

   alu_exec_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [3:0] ref_code(input logic [1:0] op, input logic [5:0] f);
      if (op == 2'b00) return 4'b0010;
      if (op == 2'b01) return 4'b0110;
      if (op == 2'b11) return 4'b0000;
      case (f)
         6'h20:   return 4'b0010;
         6'h22:   return 4'b0110;
         6'h2A:   return 4'b0111;
         6'h24:   return 4'b0000;
         6'h25:   return 4'b0001;
         6'h1A:   return 4'b1010;
         6'h1B:   return 4'b1011;
         6'h10:   return 4'b1100;
         6'h12:   return 4'b1101;
`ifdef MULT_EN
         6'h18:   return 4'b1000;
         6'h19:   return 4'b1001;
`endif
         default: return 4'b1111;
      endcase
   endfunction

   function automatic bit is_seq(input logic [3:0] c);
      return (c == 4'b1010) || (c == 4'b1011) || (c == 4'b1000) || (c == 4'b1001);
   endfunction

   function automatic logic [W-1:0] ref_result(input logic [3:0] c, input logic [W-1:0] a, b,
                                               input logic [W-1:0] h, l);
      case (c)
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b1100: return h;
         4'b1101: return l;
         default: return 0;
      endcase
   endfunction

   int             cyc = 0;
   int             m_done = -1;
   logic [W-1:0]   m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   bit             p_dbz = 1'b0;

   always @(negedge clk) begin
      logic [3:0]  ec;
      logic [W-1:0] er;
      longint      sa, sb, q, r;
      logic [63:0] up;
      if (chk_en) begin
         ec = ref_code(bus.alu_op, bus.funct);
         if (m_done < 0 && bus.op_valid && is_seq(ec)) begin
            sa = longint'($signed(bus.src_a));
            sb = longint'($signed(bus.src_b));
            p_dbz = 1'b0;
            if (ec == 4'b1010 || ec == 4'b1011) begin
               if (bus.src_b == 0) begin
                  p_hi = bus.src_a; p_lo = '1; p_dbz = 1'b1;
               end else begin
                  if (ec == 4'b1011) begin
                     sa = longint'({32'b0, bus.src_a});
                     sb = longint'({32'b0, bus.src_b});
                  end
                  q = sa / sb; r = sa % sb;
                  p_lo = q[W-1:0]; p_hi = r[W-1:0];
               end
            end else begin
               if (ec == 4'b1000) up = 64'(sa * sb);
               else up = {32'b0, bus.src_a} * {32'b0, bus.src_b};
               p_hi = up[63:32]; p_lo = up[31:0];
            end
            m_done = cyc + (p_dbz ? 1 : W + 1);
         end
         check("alu_control", 64'(bus.alu_control), 64'(ec));
         if (!is_seq(ec)) begin
            er = ref_result(ec, bus.src_a, bus.src_b, m_hi, m_lo);
            check("result", 64'(bus.result), 64'(er));
            check("zero", 64'(bus.zero), 64'(er == 0));
         end
         check("stall", 64'(bus.stall), 64'(m_done >= 0 && cyc < m_done));
         check("div_by_zero", 64'(bus.div_by_zero), 64'(m_done >= 0 && cyc == m_done && p_dbz));
         check("hi", 64'(bus.hi), 64'(m_hi));
         check("lo", 64'(bus.lo), 64'(m_lo));
         if (m_done >= 0 && cyc == m_done) begin
            m_hi = p_hi; m_lo = p_lo; m_done = -1;
         end
         if (reset) begin
            m_hi = '0; m_lo = '0; m_done = -1;
         end
      end
      cyc++;
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents an instruction and returns at the negedge of its last (non-stalled) cycle.
   task automatic exec(input bit v, input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b, output int stalls);
      bus.op_valid = v; bus.alu_op = op; bus.funct = f; bus.src_a = a; bus.src_b = b;
      stalls = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.stall) return;
         stalls++;
      end
      n_tests++; n_fail++;
      $display("FAIL stall_timeout: stall still high after %0d cycles", stalls);
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return 0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      logic [5:0] functs [12];
      functs = '{6'h20, 6'h22, 6'h2A, 6'h24, 6'h25, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h18, 6'h19, 6'h3F};
      reset = 1'b1;
      bus.op_valid = 1'b0; bus.alu_op = 2'b00; bus.funct = 6'h0; bus.src_a = '0; bus.src_b = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_stall", 64'(bus.stall), 64'd0);
      check("reset_hi", 64'(bus.hi), 64'd0);
      check("reset_lo", 64'(bus.lo), 64'd0);
      step();

      exec(1, 2'b10, 6'h22, 5, 5, st);
      check("sub_code", 64'(bus.alu_control), 64'h6);
      check("sub_result", 64'(bus.result), 64'd0);
      check("sub_zero", 64'(bus.zero), 64'd1);
      check("sub_stall", 64'(st), 64'd0);
      step();
      exec(1, 2'b10, 6'h2A, 32'hFFFF_FFFF, 1, st);
      check("slt_result", 64'(bus.result), 64'd1);
      step();
      exec(1, 2'b10, 6'h20, 32'hFFFF_FFFF, 1, st);
      check("add_wrap", 64'(bus.result), 64'd0);
      check("add_zero", 64'(bus.zero), 64'd1);
      step();

      exec(1, 2'b10, 6'h1A, -32'sd7, 2, st);
      check("div_stalls", 64'(st), 64'd33);
      check("div_done_stall", 64'(bus.stall), 64'd0);
      step();
      exec(1, 2'b10, 6'h12, 0, 0, st);
      check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
      check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);
      check("mflo", 64'(bus.result), 64'hFFFF_FFFD);
      step();

      exec(1, 2'b10, 6'h1B, 100, 0, st);
      check("dbz_stalls", 64'(st), 64'd1);
      check("dbz_pulse", 64'(bus.div_by_zero), 64'd1);
      step();
      exec(0, 2'b10, 6'h20, 0, 0, st);
      check("dbz_pulse_end", 64'(bus.div_by_zero), 64'd0);
      check("dbz_lo", 64'(bus.lo), 64'hFFFF_FFFF);
      check("dbz_hi", 64'(bus.hi), 64'd100);
      step();

      exec(1, 2'b10, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, st);
      step();
      exec(1, 2'b10, 6'h10, 0, 0, st);
      check("min_lo", 64'(bus.lo), 64'h8000_0000);
      check("min_hi", 64'(bus.hi), 64'd0);
      step();

      exec(1, 2'b10, 6'h3F, 7, 9, st);
      check("bad_code", 64'(bus.alu_control), 64'hF);
      check("bad_result", 64'(bus.result), 64'd0);
      step();

      exec(1, 2'b10, 6'h1A, -32'sd7, 2, st);
      step();
      bus.op_valid = 1'b1; bus.alu_op = 2'b10; bus.funct = 6'h1A; bus.src_a = 50; bus.src_b = 7;
      repeat (11) @(negedge clk);
      check("mid_busy", 64'(bus.stall), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b1; bus.op_valid = 1'b0;
      step();
      reset = 1'b0;
      @(negedge clk);
      check("rst_stall", 64'(bus.stall), 64'd0);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      step();
      exec(1, 2'b10, 6'h1A, 9, 3, st);
      step();
      exec(1, 2'b10, 6'h12, 0, 0, st);
      check("div93", 64'(bus.result), 64'd3);
      step();

`ifdef MULT_EN
      exec(1, 2'b10, 6'h18, 32'hFFFF_FFFF, 2, st);
      check("mult_stalls", 64'(st), 64'd33);
      step();
      exec(1, 2'b10, 6'h10, 0, 0, st);
      check("mult_hi", 64'(bus.result), 64'hFFFF_FFFF);
      check("mult_lo", 64'(bus.lo), 64'hFFFF_FFFE);
      step();
`else
      exec(1, 2'b10, 6'h18, 32'hFFFF_FFFF, 2, st);
      check("nomult_code", 64'(bus.alu_control), 64'hF);
      check("nomult_stall", 64'(st), 64'd0);
      step();
`endif

      for (int i = 0; i < 400; i++) begin
         exec($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              functs[$urandom_range(0, 11)], rnd_operand(), rnd_operand(), st);
         step();
      end

      bus.op_valid = 1'b0;
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
